// File: rtl/hs_pipe_pkg.sv
// Shared types and helpers for the clocked handshake pipeline controller.
package hs_pipe_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_HOLD  = 2'd2,
      S_RTZ   = 2'd3
   } stage_state_e;

   localparam int PHASES_4 = 4;
   localparam int PHASES_2 = 2;

   // A request is pending when the upstream side has asked for a token that has not been acknowledged yet.
   function automatic logic pending(input logic req, input logic ack, input int phases);
      logic p;
      if (phases == PHASES_4) begin
         p = req & ~ack;
      end else begin
         p = req ^ ack;
      end
      return p;
   endfunction

endpackage

// File: rtl/hs_stage.sv
// One handshake stage: captures a token, waits DELAY cycles, then offers it downstream.
module hs_stage
   import hs_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DELAY  = 15,
   parameter int PHASES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             ack_o,
   output logic             req_o,
   input  logic             ack_i,
   output logic [WIDTH-1:0] data_o,
   output stage_state_e     state_o
);

   localparam bit         IS_4PH   = (PHASES == PHASES_4);
   localparam logic [7:0] CNT_INIT = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;

   stage_state_e     state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ack_up_q, ack_up_d;
   logic             req_dn_q, req_dn_d;
   logic             req_dn_entry_s;

   assign req_dn_entry_s = IS_4PH ? 1'b1 : ~req_dn_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      req_dn_d = req_dn_q;
      // Upstream return-to-zero is independent of the FSM state
      if (IS_4PH && ack_up_q && !req_i) begin
         ack_up_d = 1'b0;
      end else begin
         ack_up_d = ack_up_q;
      end
      case (state_q)
         S_IDLE: begin
            if (pending(req_i, ack_up_q, PHASES)) begin
               data_d   = data_i;
               ack_up_d = IS_4PH ? 1'b1 : ~ack_up_q;
               if (DELAY == 0) begin
                  state_d  = S_HOLD;
                  req_dn_d = req_dn_entry_s;
               end else begin
                  state_d = S_DELAY;
                  cnt_d   = CNT_INIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DELAY: begin
            if (cnt_q == 8'd0) begin
               state_d  = S_HOLD;
               req_dn_d = req_dn_entry_s;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (IS_4PH) begin
               if (ack_i) begin
                  req_dn_d = 1'b0;
                  state_d  = S_RTZ;
               end else begin
                  state_d = S_HOLD;
               end
            end else begin
               if (ack_i == req_dn_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_RTZ: begin
            if (!ack_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RTZ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         data_q   <= '0;
         ack_up_q <= 1'b0;
         req_dn_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         ack_up_q <= ack_up_d;
         req_dn_q <= req_dn_d;
      end
   end

   assign ack_o   = ack_up_q;
   assign req_o   = req_dn_q;
   assign data_o  = data_q;
   assign state_o = state_q;

endmodule

// File: rtl/hs_pipeline_ctrl.sv
// NSTAGES chained handshake stages; HS_PIPE_STATS_EN adds token and occupancy counters.
module hs_pipeline_ctrl
   import hs_pipe_pkg::*;
#(
   parameter int NSTAGES = 2,
   parameter int WIDTH   = 32,
   parameter int DELAY   = 15,
   parameter int PHASES  = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             req_in_i,
   output logic                             ack_in_o,
   input  logic [WIDTH-1:0]                 data_in_i,
   output logic                             req_out_o,
   input  logic                             ack_out_i,
   output logic [WIDTH-1:0]                 data_out_o,
   output logic                             busy_o
`ifdef HS_PIPE_STATS_EN
   ,
   output logic [31:0]                      tokens_o,
   output logic [$clog2(NSTAGES+1)-1:0]     occ_o
`endif
);

   logic [NSTAGES:0]            req_s;
   logic [NSTAGES:0]            ack_s;
   logic [NSTAGES:0][WIDTH-1:0] data_s;
   stage_state_e                state_s [NSTAGES];
   logic                        busy_s;

   assign req_s[0]       = req_in_i;
   assign data_s[0]      = data_in_i;
   assign ack_s[NSTAGES] = ack_out_i;

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      hs_stage #(
         .WIDTH  (WIDTH),
         .DELAY  (DELAY),
         .PHASES (PHASES)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .req_i   (req_s[k]),
         .data_i  (data_s[k]),
         .ack_o   (ack_s[k]),
         .req_o   (req_s[k+1]),
         .ack_i   (ack_s[k+1]),
         .data_o  (data_s[k+1]),
         .state_o (state_s[k])
      );
   end

   always_comb begin
      busy_s = 1'b0;
      for (int k = 0; k < NSTAGES; k++) begin
         if (state_s[k] != S_IDLE) begin
            busy_s = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
   end

   assign ack_in_o   = ack_s[0];
   assign req_out_o  = req_s[NSTAGES];
   assign data_out_o = data_s[NSTAGES];
   assign busy_o     = busy_s;

`ifdef HS_PIPE_STATS_EN
   localparam int OCC_W = $clog2(NSTAGES + 1);

   logic [OCC_W-1:0] occ_s;
   logic [31:0]      tokens_q, tokens_d;
   logic             out_done_s;

   always_comb begin
      occ_s = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         if (state_s[k] != S_IDLE) begin
            occ_s = occ_s + OCC_W'(1);
         end else begin
            occ_s = occ_s;
         end
      end
   end

   // An output handshake completes on the edge where the last stage leaves S_HOLD
   always_comb begin
      if (PHASES == PHASES_4) begin
         out_done_s = (state_s[NSTAGES-1] == S_HOLD) && ack_out_i;
      end else begin
         out_done_s = (state_s[NSTAGES-1] == S_HOLD) && (ack_out_i == req_out_o);
      end
      if (out_done_s) begin
         tokens_d = tokens_q + 32'd1;
      end else begin
         tokens_d = tokens_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tokens_q <= 32'd0;
      end else begin
         tokens_q <= tokens_d;
      end
   end

   assign tokens_o = tokens_q;
   assign occ_o    = occ_s;
`endif

endmodule

// File: tb/tb_hs_pipeline_ctrl.sv
// Directed bench for hs_pipeline_ctrl: a 2-stage 4-phase instance and a 1-stage 2-phase instance.
module tb_hs_pipeline_ctrl;

   localparam int NA    = 2;
   localparam int DA    = 3;
   localparam int LAT_A = NA * (DA + 1);
   localparam int NB    = 1;
   localparam int DB    = 0;
   localparam int LAT_B = NB * (DB + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        reqa, acka_in, reqa_out, acka_out, busya;
   logic [31:0] dataa, dataa_out;
   logic        cons_en_a, cons_man_a;
   logic        reqb, ackb_in, reqb_out, ackb_out, busyb;
   logic [31:0] datab, datab_out;
`ifdef HS_PIPE_STATS_EN
   logic [31:0] tokens_a, tokens_b;
   logic [1:0]  occ_a;
   logic [0:0]  occ_b;
`endif

   assign acka_out = cons_en_a ? reqa_out : cons_man_a;
   assign ackb_out = reqb_out;

   hs_pipeline_ctrl #(.NSTAGES(NA), .WIDTH(32), .DELAY(DA), .PHASES(4)) dut_a (
      .clk_i(clk), .rst_i(rst), .req_in_i(reqa), .ack_in_o(acka_in), .data_in_i(dataa),
      .req_out_o(reqa_out), .ack_out_i(acka_out), .data_out_o(dataa_out), .busy_o(busya)
`ifdef HS_PIPE_STATS_EN
      , .tokens_o(tokens_a), .occ_o(occ_a)
`endif
   );

   hs_pipeline_ctrl #(.NSTAGES(NB), .WIDTH(32), .DELAY(DB), .PHASES(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .req_in_i(reqb), .ack_in_o(ackb_in), .data_in_i(datab),
      .req_out_o(reqb_out), .ack_out_i(ackb_out), .data_out_o(datab_out), .busy_o(busyb)
`ifdef HS_PIPE_STATS_EN
      , .tokens_o(tokens_b), .occ_o(occ_b)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction model: tokens enter on an upstream acknowledge event and must leave in order.
   logic [31:0] qa_data[$];
   int          qa_cyc[$];
   logic [31:0] out_log_a[$];
   logic [31:0] qb_data[$];
   int          qb_cyc[$];
   logic [31:0] out_log_b[$];

   initial begin
      logic        pa_ack, pa_req, pb_ack, pb_req;
      logic [31:0] hold_a, hold_b;
      pa_ack = 1'b0; pa_req = 1'b0; pb_ack = 1'b0; pb_req = 1'b0;
      hold_a = 32'd0; hold_b = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            qa_data.delete(); qa_cyc.delete(); qb_data.delete(); qb_cyc.delete();
            pa_ack = 1'b0; pa_req = 1'b0; pb_ack = 1'b0; pb_req = 1'b0;
            hold_a = 32'd0; hold_b = 32'd0;
         end else begin
            if (acka_in && !pa_ack) begin
               qa_data.push_back(dataa);
               qa_cyc.push_back(cyc);
            end
            if (reqa_out && !pa_req) begin
               check("a_out_has_token", 32'(qa_data.size() != 0), 32'd1);
               if (qa_data.size() != 0) begin
                  check("a_out_order", dataa_out, qa_data[0]);
                  check("a_latency_min", 32'((cyc - qa_cyc[0]) >= LAT_A - 1), 32'd1);
                  void'(qa_data.pop_front());
                  void'(qa_cyc.pop_front());
               end
               out_log_a.push_back(dataa_out);
               hold_a = dataa_out;
            end else if (reqa_out) begin
               check("a_out_stable", dataa_out, hold_a);
            end
            check("a_inflight_bound", 32'(qa_data.size() <= NA), 32'd1);
            if (ackb_in != pb_ack) begin
               qb_data.push_back(datab);
               qb_cyc.push_back(cyc);
            end
            if (reqb_out != pb_req) begin
               check("b_out_has_token", 32'(qb_data.size() != 0), 32'd1);
               if (qb_data.size() != 0) begin
                  check("b_out_order", datab_out, qb_data[0]);
                  check("b_latency_min", 32'((cyc - qb_cyc[0]) >= LAT_B - 1), 32'd1);
                  void'(qb_data.pop_front());
                  void'(qb_cyc.pop_front());
               end
               out_log_b.push_back(datab_out);
               hold_b = datab_out;
            end else begin
               check("b_out_stable", datab_out, hold_b);
            end
`ifdef HS_PIPE_STATS_EN
            check("a_occ_bound", 32'(occ_a <= 2'(NA)), 32'd1);
            check("a_occ_busy", 32'(occ_a != 2'd0), 32'(busya));
            check("b_occ_busy", 32'(occ_b != 1'b0), 32'(busyb));
`endif
            pa_ack = acka_in; pa_req = reqa_out;
            pb_ack = ackb_in; pb_req = reqb_out;
         end
      end
   end

   task automatic wait_a_ack(input logic val, input string name);
      int n = 0;
      while (acka_in !== val && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(acka_in), 32'(val));
   endtask

   task automatic wait_idle_a(input string name);
      int n = 0;
      while (busya !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busya), 32'd0);
   endtask

   task automatic put_a(input logic [31:0] d);
      reqa  = 1'b1;
      dataa = d;
      @(negedge clk);
      wait_a_ack(1'b1, "put_a_ack");
      reqa = 1'b0;
      @(negedge clk);
      wait_a_ack(1'b0, "put_a_rtz");
   endtask

   task automatic put_b(input logic [31:0] d);
      logic p, want;
      int   n;
      p     = ackb_in;
      want  = ~p;
      n     = 0;
      reqb  = ~reqb;
      datab = d;
      @(negedge clk);
      while (ackb_in === p && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("put_b_ack", 32'(ackb_in), 32'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nlog;
      rst = 1'b1; reqa = 1'b0; dataa = 32'd0; cons_en_a = 1'b1; cons_man_a = 1'b0;
      reqb = 1'b0; datab = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_a_ack", 32'(acka_in), 32'd0);
      check("rst_a_req", 32'(reqa_out), 32'd0);
      check("rst_a_data", dataa_out, 32'd0);
      check("rst_a_busy", 32'(busya), 32'd0);
      check("rst_b_ack", 32'(ackb_in), 32'd0);
      check("rst_b_req", 32'(reqb_out), 32'd0);
      check("rst_b_data", datab_out, 32'd0);
`ifdef HS_PIPE_STATS_EN
      check("rst_a_tokens", tokens_a, 32'd0);
      check("rst_a_occ", 32'(occ_a), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Single token, exact latency: ack one cycle after, req_out 8 cycles after.
      reqa = 1'b1; dataa = 32'hA5;
      check("t1_ack_before", 32'(acka_in), 32'd0);
      @(negedge clk);
      check("t1_ack_at_1", 32'(acka_in), 32'd1);
      check("t1_busy", 32'(busya), 32'd1);
      reqa = 1'b0;
      repeat (6) @(negedge clk);
      check("t1_req_out_early", 32'(reqa_out), 32'd0);
      @(negedge clk);
      check("t1_req_out_at_8", 32'(reqa_out), 32'd1);
      check("t1_data_out", dataa_out, 32'hA5);
      wait_idle_a("t1_drain");

      // Request held high: no second capture, ack clears one cycle after the drop.
      nlog = out_log_a.size();
      reqa = 1'b1; dataa = 32'h5A;
      @(negedge clk);
      wait_a_ack(1'b1, "t2_ack");
      repeat (25) begin
         @(negedge clk);
         check("t2_ack_held", 32'(acka_in), 32'd1);
      end
      check("t2_one_token", 32'(out_log_a.size()), 32'(nlog + 1));
      check("t2_token_val", out_log_a[nlog], 32'h5A);
      check("t2_idle", 32'(busya), 32'd0);
      reqa = 1'b0;
      check("t2_ack_before_drop", 32'(acka_in), 32'd1);
      @(negedge clk);
      check("t2_ack_cleared", 32'(acka_in), 32'd0);

      // Back-pressure: two tokens fill the pipe, the third waits for a downstream ack.
      cons_en_a = 1'b0; cons_man_a = 1'b0;
      nlog = out_log_a.size();
      put_a(32'h11);
      put_a(32'h22);
      reqa = 1'b1; dataa = 32'h33;
      repeat (30) begin
         @(negedge clk);
         check("t3_third_blocked", 32'(acka_in), 32'd0);
      end
      check("t3_req_out_held", 32'(reqa_out), 32'd1);
      check("t3_data_out_held", dataa_out, 32'h11);
      check("t3_busy", 32'(busya), 32'd1);
      cons_man_a = 1'b1;
      @(negedge clk);
      check("t3_release", 32'(reqa_out), 32'd0);
      cons_man_a = 1'b0;
      wait_a_ack(1'b1, "t3_third_ack");
      reqa = 1'b0;
      @(negedge clk);
      wait_a_ack(1'b0, "t3_third_rtz");
      cons_en_a = 1'b1;
      wait_idle_a("t3_drain");
      check("t3_count", 32'(out_log_a.size()), 32'(nlog + 3));
      check("t3_order0", out_log_a[nlog], 32'h11);
      check("t3_order1", out_log_a[nlog + 1], 32'h22);
      check("t3_order2", out_log_a[nlog + 2], 32'h33);

      // Reset while stage 0 is counting down: the token vanishes.
      reqa = 1'b1; dataa = 32'h77;
      @(negedge clk);
      check("t4_ack", 32'(acka_in), 32'd1);
      reqa = 1'b0;
      @(negedge clk);
      check("t4_busy_before", 32'(busya), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t4_ack_rst", 32'(acka_in), 32'd0);
      check("t4_req_rst", 32'(reqa_out), 32'd0);
      check("t4_data_rst", dataa_out, 32'd0);
      check("t4_busy_rst", 32'(busya), 32'd0);
      rst = 1'b0;
      repeat (15) begin
         @(negedge clk);
         check("t4_no_req_out", 32'(reqa_out), 32'd0);
      end
      check("t4_idle", 32'(busya), 32'd0);

      // Two-phase, zero delay, single stage with an echoing consumer.
      for (int i = 1; i <= 4; i++) begin
         put_b(32'(i));
      end
      repeat (5) @(negedge clk);
      check("t5_toggles", 32'(out_log_b.size()), 32'd4);
      check("t5_seq0", out_log_b[0], 32'd1);
      check("t5_seq1", out_log_b[1], 32'd2);
      check("t5_seq2", out_log_b[2], 32'd3);
      check("t5_seq3", out_log_b[3], 32'd4);
      check("t5_req_out_final", 32'(reqb_out), 32'd0);
      check("t5_idle", 32'(busyb), 32'd0);
`ifdef HS_PIPE_STATS_EN
      check("t5_tokens_b", tokens_b, 32'd4);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_tokens_rst", tokens_a, 32'd0);
      check("t6_occ_rst", 32'(occ_a), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         put_a(32'h100 + 32'(i));
      end
      wait_idle_a("t6_drain");
      check("t6_tokens", tokens_a, 32'd5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hs_pipeline_ctrl.md
Name: hs_pipeline_ctrl

Overview:
Clocked, parametrised successor to the single-stage asynchronous req/ack controller. It chains NSTAGES handshake stages, each with a matched-delay counter of DELAY cycles and a WIDTH-bit data latch. The handshake protocol is selectable: 4-phase (return-to-zero) or 2-phase (transition signalling). It sits between handshake producers and consumers in the synchronous emulation of the asynchronous Ibex datapath.

Parameters:
NSTAGES, 2, number of chained stages (1..16)
WIDTH, 32, data width carried per token
DELAY, 15, matched-delay cycles per stage (0..255; 0 means no delay state)
PHASES, 4, protocol: 4 = return-to-zero, 2 = transition

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_in_i  in  1  upstream request
ack_in_o  out  1  upstream acknowledge
data_in_i  in  WIDTH  upstream data, valid with req_in_i
req_out_o  out  1  downstream request
ack_out_i  in  1  downstream acknowledge
data_out_o  out  WIDTH  downstream data, stable while request is pending
busy_o  out  1  at least one stage not in S_IDLE

Behaviour:
- Reset: all outputs 0; every stage in S_IDLE; counters 0; data latches 0; ack_up and req_dn flags 0. A reset asserted mid-transfer drops in-flight tokens with no handshake completion.
- Stage k upstream is stage k-1, or the ports for k=0. Downstream is stage k+1, or the ports for k=NSTAGES-1. ack_in_o is the ack_up flag of stage 0. req_out_o and data_out_o come from the last stage.
- Pending request: PHASES=4: req=1 and ack_up=0. PHASES=2: req != ack_up.
- Per-stage FSM:
  - S_IDLE: on a pending request, latch data, then PHASES=4: set ack_up=1; PHASES=2: toggle ack_up. Go to S_DELAY with cnt=DELAY-1, or to S_HOLD if DELAY=0.
  - S_DELAY: decrement cnt. At cnt=0, go to S_HOLD.
  - S_HOLD: on entry, PHASES=4: req_dn=1; PHASES=2: toggle req_dn.
    - PHASES=4: when ack=1, set req_dn=0 and go to S_RTZ.
    - PHASES=2: when ack==req_dn, go to S_IDLE.
  - S_RTZ (PHASES=4 only): when ack=0, go to S_IDLE.
- Upstream return-to-zero (PHASES=4): ack_up clears in the cycle after req is sampled 0. This is independent of FSM state.
- A new capture requires S_IDLE and a pending request. In PHASES=4 this forces upstream RTZ before a second token is accepted.
- Latency: from req sampled pending to that stage's request visible is DELAY+1 cycles. End to end, with a non-blocking consumer, this is NSTAGES*(DELAY+1).
- The data latch is written only on capture. It is held through S_DELAY, S_HOLD and S_RTZ.
- Simultaneous events:
  - Capture and ack_up clear never coincide in one stage, because capture requires ack_up=0 in 4-phase.
  - In PHASES=4, an ack arriving on the same edge as S_HOLD entry is sampled on the next cycle.
  - Back-pressure: a stalled downstream holds every upstream stage in S_HOLD. Tokens are never lost or duplicated.
- Protocol violation (downstream ack without a pending request): ignored in S_IDLE and S_DELAY.

Optional Feature:
HS_PIPE_STATS_EN
- Defined: adds ports tokens_o (out, 32 bits) and occ_o (out, $clog2(NSTAGES+1) bits), both reset to 0.
  - tokens_o increments once per completed output handshake (S_HOLD exit of the last stage). It wraps at 2^32.
  - occ_o equals the number of stages not in S_IDLE.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package hs_pipe_pkg holds:
  - typedef enum logic [1:0] stage_state_e {S_IDLE, S_DELAY, S_HOLD, S_RTZ}
  - localparam PHASES_4 = 4 and PHASES_2 = 2
  - function pending(req, ack, phases)
- One sub-module, hs_stage (parameters WIDTH, DELAY, PHASES), instantiated NSTAGES times via generate. The top level contains only wiring, busy_o and the stats logic.

Test Plan:
- NSTAGES=2, DELAY=3, PHASES=4: req_in_i=1 with data 0xA5 at cycle 2 -> ack_in_o=1 at cycle 3; req_out_o=1 at cycle 10 with data_out_o=0xA5.
- Same configuration, ack_out_i held 0: three tokens offered -> only two accepted (ack_in_o does not rise for the third); the first releases after ack_out_i pulses; order is preserved.
- PHASES=2, DELAY=0, NSTAGES=1: toggle req_in_i 4 times with data 1..4 and echo req_out_o onto ack_out_i -> 4 req_out_o toggles; data_out_o sequence 1,2,3,4.
- PHASES=4: req_in_i held high after ack -> no second capture until req_in_i=0; ack_in_o clears one cycle after.
- Reset asserted while stage 0 is in S_DELAY -> all outputs 0 next cycle; busy_o=0; no req_out_o.
- HS_PIPE_STATS_EN defined: 5 tokens streamed -> tokens_o=5; occ_o never exceeds NSTAGES.
